// File: rtl/tlul_sram_bridge.sv
// rtl/tlul_sram_bridge.sv - TL-UL device adapter in front of a single-port 32-bit word SRAM
//
// Purpose:
//   Accepts TL-UL A-channel requests, drives the SRAM macro combinationally on the
//   handshake edge, captures the SRAM read word one cycle later, and returns in-order
//   D-channel responses through a small response FIFO that absorbs D backpressure.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   a_*                      TL-UL A channel (request) from the crossbar
//   d_*                      TL-UL D channel (response) to the crossbar
//   ram_en_o/we_o/di_o/a_o   SRAM enable, byte write mask, write data, word address
//   ram_do_i                 SRAM read data, valid the cycle after ram_en_o
//
// Optional feature (macro TLUL_SRAM_RD_MASK_EN):
//   When defined, Get responses zero every byte whose a_mask_i bit was 0.

module tlul_sram_bridge #(
    parameter int          AW    = 12,
    parameter int          SRC_W = 8,
    parameter int          DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h2000_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [2:0]       a_opcode_i,
    input  logic [1:0]       a_size_i,
    input  logic [31:0]      a_address_i,
    input  logic [3:0]       a_mask_i,
    input  logic [31:0]      a_data_i,
    input  logic [SRC_W-1:0] a_source_i,
    output logic             d_valid_o,
    input  logic             d_ready_i,
    output logic [2:0]       d_opcode_o,
    output logic [1:0]       d_size_o,
    output logic [SRC_W-1:0] d_source_o,
    output logic [31:0]      d_data_o,
    output logic             d_error_o,
    output logic             ram_en_o,
    output logic [3:0]       ram_we_o,
    output logic [31:0]      ram_di_o,
    output logic [AW-1:0]    ram_a_o,
    input  logic [31:0]      ram_do_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]       op;
        logic [1:0]       size;
        logic [SRC_W-1:0] src;
        logic [31:0]      data;
        logic             err;
    } rsp_t;

    // A-channel decode and SRAM drive
    logic a_get, a_put, a_err, fire;

    always_comb begin
        a_get = (a_opcode_i == 3'd4);
        a_put = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
        a_err = !(a_get || a_put)
              || (a_address_i[31:AW+2] != BASE[31:AW+2])
              || ((a_size_i == 2'd2) && (a_address_i[1:0] != 2'b00))
              || ((a_opcode_i == 3'd0) && (a_mask_i != 4'hF));
    end

    logic [CW-1:0] cnt_q, cnt_d;

    // Outstanding count covers the capture stage plus FIFO, so a full count
    // guarantees the FIFO can never be pushed past DEPTH.
    assign a_ready_o = (cnt_q < CW'(DEPTH));
    assign fire      = a_valid_i && a_ready_o;
    assign ram_en_o  = fire && !a_err;
    assign ram_a_o   = a_address_i[AW+1:2];
    assign ram_di_o  = a_data_i;
    assign ram_we_o  = (ram_en_o && a_put) ? a_mask_i : 4'h0;

    // Capture stage: holds the request attributes while the SRAM read completes
    logic             cap_valid_q, cap_valid_d;
    logic             cap_get_q,   cap_get_d;
    logic             cap_err_q,   cap_err_d;
    logic [1:0]       cap_size_q,  cap_size_d;
    logic [SRC_W-1:0] cap_src_q,   cap_src_d;
`ifdef TLUL_SRAM_RD_MASK_EN
    logic [3:0]       cap_mask_q,  cap_mask_d;
`endif

    always_comb begin
        cap_valid_d = fire;
        cap_get_d   = cap_get_q;
        cap_err_d   = cap_err_q;
        cap_size_d  = cap_size_q;
        cap_src_d   = cap_src_q;
`ifdef TLUL_SRAM_RD_MASK_EN
        cap_mask_d  = cap_mask_q;
`endif
        if (fire) begin
            cap_get_d  = a_get;
            cap_err_d  = a_err;
            cap_size_d = a_size_i;
            cap_src_d  = a_source_i;
`ifdef TLUL_SRAM_RD_MASK_EN
            cap_mask_d = a_mask_i;
`endif
        end
    end

    rsp_t        push_rsp;
    logic [31:0] rd_word;

    always_comb begin
`ifdef TLUL_SRAM_RD_MASK_EN
        rd_word = ram_do_i & {{8{cap_mask_q[3]}}, {8{cap_mask_q[2]}},
                              {8{cap_mask_q[1]}}, {8{cap_mask_q[0]}}};
`else
        rd_word = ram_do_i;
`endif
        push_rsp.op   = {2'b00, cap_get_q};
        push_rsp.size = cap_size_q;
        push_rsp.src  = cap_src_q;
        push_rsp.err  = cap_err_q;
        push_rsp.data = (cap_err_q || !cap_get_q) ? 32'h0 : rd_word;
    end

    // Response FIFO
    rsp_t          mem_q [DEPTH];
    rsp_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign d_valid_o  = (fcnt_q != '0);
    assign pop        = d_valid_o && d_ready_i;
    assign d_opcode_o = mem_q[rd_ptr_q].op;
    assign d_size_o   = mem_q[rd_ptr_q].size;
    assign d_source_o = mem_q[rd_ptr_q].src;
    assign d_data_o   = mem_q[rd_ptr_q].data;
    assign d_error_o  = mem_q[rd_ptr_q].err;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cap_valid_q) begin
            mem_d[wr_ptr_q] = push_rsp;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        fcnt_d = fcnt_q + CW'(cap_valid_q) - CW'(pop);
        cnt_d  = cnt_q + CW'(fire) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_valid_q <= 1'b0;
            cap_get_q   <= 1'b0;
            cap_err_q   <= 1'b0;
            cap_size_q  <= '0;
            cap_src_q   <= '0;
`ifdef TLUL_SRAM_RD_MASK_EN
            cap_mask_q  <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_get_q   <= cap_get_d;
            cap_err_q   <= cap_err_d;
            cap_size_q  <= cap_size_d;
            cap_src_q   <= cap_src_d;
`ifdef TLUL_SRAM_RD_MASK_EN
            cap_mask_q  <= cap_mask_d;
`endif
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tlul_sram_bridge.sv
// tb/tb_tlul_sram_bridge.sv - self-checking bench for tlul_sram_bridge

module tb_tlul_sram_bridge;

    localparam int          AW    = 12;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h2000_0000;

    logic        clk_i, rst_ni;
    logic        a_valid_i, a_ready_o;
    logic [2:0]  a_opcode_i;
    logic [1:0]  a_size_i;
    logic [31:0] a_address_i;
    logic [3:0]  a_mask_i;
    logic [31:0] a_data_i;
    logic [7:0]  a_source_i;
    logic        d_valid_o, d_ready_i;
    logic [2:0]  d_opcode_o;
    logic [1:0]  d_size_o;
    logic [7:0]  d_source_o;
    logic [31:0] d_data_o;
    logic        d_error_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_di_o;
    logic [AW-1:0] ram_a_o;
    logic [31:0] ram_do_i;

    tlul_sram_bridge #(.AW(AW), .SRC_W(8), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
        .a_size_i(a_size_i), .a_address_i(a_address_i), .a_mask_i(a_mask_i),
        .a_data_i(a_data_i), .a_source_i(a_source_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
        .d_size_o(d_size_o), .d_source_o(d_source_o), .d_data_o(d_data_o),
        .d_error_o(d_error_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_di_o(ram_di_o),
        .ram_a_o(ram_a_o), .ram_do_i(ram_do_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // SRAM macro: 1-cycle registered read, byte write mask
    logic [31:0] sram [4096];
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_we_o == 4'h0) begin
                ram_do_i <= sram[ram_a_o];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) sram[ram_a_o][8*b +: 8] = ram_di_o[8*b +: 8];
            end
        end
    end

    // Reference model: word memory plus queue of expected responses
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        int          rdy;
        int          acc;
        int          popc;
    } rsp_t;

    logic [31:0] ref_mem [4096];
    rsp_t        exp_q[$];
    rsp_t        log_q[$];
    int          cyc = 0;
    int          en_cnt = 0;
    logic [31:0] last_en_a;
    logic [3:0]  last_en_we;

    function automatic logic [31:0] bytemask(input logic [3:0] m);
        logic [31:0] r = 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    always @(negedge clk_i) begin
        #3;
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            logic   exp_dv, fire, err, is_get, is_put;
            int     idx;
            rsp_t   e;
            cyc++;
            chk("a_ready", a_ready_o, (exp_q.size() < DEPTH));
            exp_dv = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            chk("d_valid", d_valid_o, exp_dv);
            if (d_valid_o && exp_dv) begin
                chk("d_opcode", d_opcode_o, exp_q[0].op);
                chk("d_size",   d_size_o,   exp_q[0].size);
                chk("d_source", d_source_o, exp_q[0].src);
                chk("d_data",   d_data_o,   exp_q[0].data);
                chk("d_error",  d_error_o,  exp_q[0].err);
                if (d_ready_i) begin
                    e = exp_q.pop_front();
                    e.popc = cyc;
                    log_q.push_back(e);
                end
            end
            fire   = a_valid_i && a_ready_o;
            is_get = (a_opcode_i == 3'd4);
            is_put = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
            err    = !(is_get || is_put)
                   || ((a_address_i >> (AW + 2)) != (BASE >> (AW + 2)))
                   || (a_size_i == 2'd2 && (a_address_i % 4) != 0)
                   || (a_opcode_i == 3'd0 && a_mask_i != 4'hF);
            chk("ram_en", ram_en_o, fire && !err);
            if (ram_en_o) begin
                en_cnt++;
                last_en_a  = 32'(ram_a_o);
                last_en_we = ram_we_o;
            end
            if (fire) begin
                idx = int'((a_address_i / 4) % 4096);
                if (!err) begin
                    chk("ram_a", 32'(ram_a_o), idx);
                    chk("ram_we", ram_we_o, is_put ? a_mask_i : 4'h0);
                    if (is_put) chk("ram_di", ram_di_o, a_data_i);
                end
                e.op   = is_get ? 3'd1 : 3'd0;
                e.size = a_size_i;
                e.src  = a_source_i;
                e.err  = err;
                e.rdy  = cyc + 2;
                e.acc  = cyc;
                e.popc = 0;
                e.data = 32'h0;
                if (!err && is_get) begin
`ifdef TLUL_SRAM_RD_MASK_EN
                    e.data = ref_mem[idx] & bytemask(a_mask_i);
`else
                    e.data = ref_mem[idx];
`endif
                end
                if (!err && is_put)
                    ref_mem[idx] = (ref_mem[idx] & ~bytemask(a_mask_i)) | (a_data_i & bytemask(a_mask_i));
                exp_q.push_back(e);
            end
        end
    end

    // Drive one request starting at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [3:0] m, input logic [31:0] data, input logic [7:0] src);
        logic got = 1'b0;
        a_valid_i = 1'b1; a_opcode_i = op; a_size_i = sz; a_address_i = addr;
        a_mask_i = m; a_data_i = data; a_source_i = src;
        for (int i = 0; i < 50 && !got; i++) begin
            #3;
            got = a_ready_o;
            @(negedge clk_i);
        end
        if (!got) chk("accept_timeout", 32'(src), 32'hFFFF_FFFF);
        a_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        int n0, e0;
        for (int i = 0; i < 4096; i++) begin sram[i] = 32'h0; ref_mem[i] = 32'h0; end
        ram_do_i = 32'h0;
        rst_ni = 1'b0; d_ready_i = 1'b1;
        a_valid_i = 1'b0; a_opcode_i = 3'd0; a_size_i = 2'd0; a_address_i = 32'h0;
        a_mask_i = 4'h0; a_data_i = 32'h0; a_source_i = 8'h0;
        idle(3);
        chk("rst d_valid", d_valid_o, 0);
        chk("rst d_data", d_data_o, 0);
        chk("rst d_opcode", d_opcode_o, 0);
        chk("rst d_source", d_source_o, 0);
        chk("rst ram_en", ram_en_o, 0);
        chk("rst ram_we", ram_we_o, 0);
        rst_ni = 1'b1;
        #3 chk("rst a_ready", a_ready_o, 1);
        @(negedge clk_i);

        // Put full then Get
        n0 = log_q.size();
        send(3'd0, 2'd2, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF, 8'h10);
        chk("put ram_a lit", last_en_a, 4);
        chk("put ram_we lit", last_en_we, 4'hF);
        send(3'd4, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'h11);
        idle(4);
        chk("put ack opcode", log_q[n0].op, 0);
        chk("put ack error", log_q[n0].err, 0);
        chk("get opcode", log_q[n0+1].op, 1);
        chk("get data lit", log_q[n0+1].data, 32'hDEAD_BEEF);
        chk("get latency", log_q[n0+1].popc - log_q[n0+1].acc, 2);

        // Partial put
        n0 = log_q.size();
        send(3'd1, 2'd2, 32'h2000_0010, 4'b0100, 32'h00AA_0000, 8'h12);
        send(3'd4, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'h13);
        idle(4);
        chk("partial data lit", log_q[n0+1].data, 32'hDEAA_BEEF);

        // Error cases: bad base, misaligned, bad opcode, PutFull with partial mask
        n0 = log_q.size(); e0 = en_cnt;
        send(3'd4, 2'd2, 32'h3000_0000, 4'hF, 32'h0, 8'h20);
        send(3'd4, 2'd2, 32'h2000_0002, 4'hF, 32'h0, 8'h21);
        send(3'd2, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'h22);
        send(3'd0, 2'd2, 32'h2000_0010, 4'h7, 32'h1234_5678, 8'h23);
        idle(4);
        chk("err ram_en count", en_cnt - e0, 0);
        chk("err0 opcode", log_q[n0].op, 1);
        chk("err0 error", log_q[n0].err, 1);
        chk("err0 data", log_q[n0].data, 0);
        chk("err1 error", log_q[n0+1].err, 1);
        chk("err1 data", log_q[n0+1].data, 0);
        chk("err2 opcode", log_q[n0+2].op, 0);
        chk("err2 error", log_q[n0+2].err, 1);
        chk("err3 error", log_q[n0+3].err, 1);

        // Backpressure: 4 outstanding fill the bridge, 5th waits
        n0 = log_q.size();
        d_ready_i = 1'b0;
        for (int s = 1; s <= 4; s++) send(3'd4, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'(s));
        #3 chk("full a_ready", a_ready_o, 0);
        @(negedge clk_i);
        fork
            send(3'd4, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'd5);
            begin idle(6); d_ready_i = 1'b1; end
        join
        idle(8);
        for (int s = 0; s < 5; s++) begin
            chk("bp source", log_q[n0+s].src, s + 1);
            chk("bp data", log_q[n0+s].data, 32'hDEAA_BEEF);
        end

        // Reset with responses queued
        d_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) send(3'd4, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 8'(8'h31 + s));
        idle(3);
        n0 = log_q.size();
        #2 rst_ni = 1'b0;
        #1 chk("rst mid d_valid", d_valid_o, 0);
        chk("rst mid a_ready", a_ready_o, 1);
        idle(2);
        rst_ni = 1'b1;
        d_ready_i = 1'b1;
        idle(6);
        chk("no stale beats", log_q.size() - n0, 0);

        // Read byte mask
        n0 = log_q.size();
        send(3'd0, 2'd2, 32'h2000_0020, 4'hF, 32'hDEAD_BEEF, 8'h40);
        send(3'd4, 2'd2, 32'h2000_0020, 4'b0011, 32'h0, 8'h41);
        idle(4);
`ifdef TLUL_SRAM_RD_MASK_EN
        chk("rdmask data lit", log_q[n0+1].data, 32'h0000_BEEF);
`else
        chk("rdmask data lit", log_q[n0+1].data, 32'hDEAD_BEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlul_sram_bridge.md
Name: tlul_sram_bridge

Overview:
TL-UL device adapter that sits directly upstream of the single-port 32-bit word SRAM macro. The SRAM has a 1-cycle registered read and a byte write mask.
- Accepts TL-UL A-channel requests from the crossbar.
- Drives the SRAM enable, byte-write-mask, data and address pins.
- Captures the SRAM read word one cycle later.
- Returns in-order D-channel responses through a small response FIFO, which absorbs D-channel backpressure.

Parameters:
AW, 12, SRAM word-address width (4096 words)
SRC_W, 8, width of a_source/d_source
DEPTH, 4, maximum outstanding responses (pipeline stage + FIFO entries); must be >= 2
BASE, 32'h2000_0000, device base address; bits [31:AW+2] of a_address_i must match BASE[31:AW+2]

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_ni  input  1  asynchronous active-low reset
a_valid_i  input  1  A-channel valid
a_ready_o  output  1  A-channel ready
a_opcode_i  input  3  0=PutFullData, 1=PutPartialData, 4=Get
a_size_i  input  2  log2 bytes
a_address_i  input  32  byte address
a_mask_i  input  4  byte lanes
a_data_i  input  32  write data
a_source_i  input  SRC_W  request ID
d_valid_o  output  1  D-channel valid
d_ready_i  input  1  D-channel ready
d_opcode_o  output  3  0=AccessAck, 1=AccessAckData
d_size_o  output  2  echoed a_size
d_source_o  output  SRC_W  echoed a_source
d_data_o  output  32  read data
d_error_o  output  1  error response
ram_en_o  output  1  SRAM chip enable
ram_we_o  output  4  SRAM byte write mask
ram_di_o  output  32  SRAM write data
ram_a_o  output  AW  SRAM word address
ram_do_i  input  32  SRAM read data, valid the cycle after ram_en_o

Behaviour:
- Reset values:
  - a_ready_o=1 (after reset release).
  - d_valid_o=0; d_opcode/size/source/data/error=0.
  - ram_en_o=0, ram_we_o=0.
  - Outstanding count=0; FIFO empty; capture stage invalid.
- Acceptance: a_ready_o = (outstanding < DEPTH), registered-state only; no combinational path from d_ready_i. Handshake fire = a_valid_i & a_ready_o.
- Error classification (combinational on A fields):
  - opcode not in {0,1,4};
  - address bits [31:AW+2] != BASE bits;
  - address[1:0] != 0 while a_size_i == 2;
  - PutFullData with a_mask_i != 4'hF.
- SRAM drive:
  - ram_en_o = fire & ~err.
  - ram_a_o = a_address_i[AW+1:2].
  - ram_di_o = a_data_i.
  - ram_we_o = a_mask_i for Put opcodes, 4'h0 for Get.
  - All four outputs are combinational, so the SRAM samples on the same edge as the handshake.
- Capture stage: on fire, register opcode class, size, source, err and valid. In the following cycle, push one FIFO entry:
  - d_data = err ? 0 : (Get ? ram_do_i : 0);
  - d_opcode = Get ? 1 : 0, including erroneous Gets;
  - unsupported opcodes return AccessAck (0) with error.
- Latency: request accepted in cycle C → FIFO write at end of C+1 → d_valid_o earliest in C+2. Erroneous requests take the same path and latency; the SRAM is never touched.
- FIFO: DEPTH entries, circular read/write pointers with wrap at DEPTH-1. Pop on d_valid_o & d_ready_i. D outputs come from the head entry and are held stable while d_valid_o & ~d_ready_i.
- Outstanding count: +1 on fire, -1 on pop; simultaneous fire and pop leaves it unchanged. It never exceeds DEPTH, so the FIFO cannot overflow.
- Ordering: responses are strictly in acceptance order.
- Reset mid-operation: all in-flight and queued responses are discarded; no D beat is emitted for them after reset release.

Optional Feature:
- Macro: TLUL_SRAM_RD_MASK_EN.
- Defined: Get responses zero every byte of d_data_o whose a_mask_i bit was 0. The capture stage stores the mask for this.
- Undefined: the full 32-bit SRAM word is returned regardless of mask, and no mask is stored.

Test Plan:
- Put Full, addr 0x2000_0010, data 0xDEADBEEF, mask F, then Get same addr → ram_a_o=4, ram_we_o=F; AccessAck d_error=0; then AccessAckData d_data=0xDEADBEEF. Get accepted cycle C gives d_valid_o in C+2.
- PutPartial mask 4'b0100, data 0x00AA0000 over 0xDEADBEEF, then Get → d_data=0xDEAABEEF.
- Get to 0x3000_0000, then Get to 0x2000_0002 with size 2 → both AccessAckData, d_error=1, d_data=0, ram_en_o never asserted.
- Hold d_ready_i=0, issue back-to-back Gets with sources 1..5:
  - a_ready_o drops after the 4th accept; the 5th waits.
  - Release d_ready_i → responses arrive with sources 1,2,3,4 and then 5, data intact and stable while stalled.
- Assert rst_ni low with 3 responses queued → d_valid_o=0 immediately; no stale beat after release; a_ready_o=1.
- With TLUL_SRAM_RD_MASK_EN defined: Get mask 4'b0011 on 0xDEADBEEF → d_data=0x0000BEEF. With it undefined → 0xDEADBEEF.
